vpifo_req_sched: RTL

Round-robin request scheduler that shares the single push/pop port of the virtualized PIFO I/O port among TREE_NUM tenant requesters, one per virtual tree. Each cycle it issues at most one push or pop. It retries tasks rejected by task-FIFO-full, masking the congested root sub-tree for a back-off window, and drops a task after RETRY_MAX rejections. It tracks in-flight pops and returns pop data to the owning tenant after the fixed port latency.

---
 rtl/vpifo_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/vpifo_req_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vpifo_pkg.sv
package vpifo_pkg;

  localparam int unsigned PTW_DEF       = 16;
  localparam int unsigned MTW_DEF       = 0;
  localparam int unsigned LEVEL_DEF     = 4;
  localparam int unsigned TREE_NUM_DEF  = 4;
  localparam int unsigned POP_LAT_DEF   = 2;
  localparam int unsigned BACKOFF_DEF   = 4;
  localparam int unsigned RETRY_MAX_DEF = 3;

  localparam int unsigned DW            = MTW_DEF + PTW_DEF;
  localparam int unsigned TREE_NUM_BITS = $clog2(TREE_NUM_DEF);
  localparam int unsigned LEVEL_BITS    = $clog2(LEVEL_DEF);

  localparam logic [DW-1:0] ALL_ONES = '1;

  typedef struct packed {
    logic                     valid;
    logic [TREE_NUM_BITS-1:0] tree_id;
  } inflight_t;

  function automatic int unsigned root_of(input int unsigned id, input int unsigned level);
    return id & (level - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
module rr_arbiter
  import vpifo_pkg::*;
#(
  parameter int unsigned N     = TREE_NUM_DEF,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // N is a power of two, so the IDX_W-bit add wraps the search modulo N.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/vpifo_req_sched.sv
module vpifo_req_sched
  import vpifo_pkg::*;
#(
  parameter int unsigned PTW       = PTW_DEF,
  parameter int unsigned MTW       = MTW_DEF,
  parameter int unsigned LEVEL     = LEVEL_DEF,
  parameter int unsigned TREE_NUM  = TREE_NUM_DEF,
  parameter int unsigned POP_LAT   = POP_LAT_DEF,
  parameter int unsigned BACKOFF   = BACKOFF_DEF,
  parameter int unsigned RETRY_MAX = RETRY_MAX_DEF,
  localparam int unsigned DATA_W   = MTW + PTW,
  localparam int unsigned ID_W     = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic [TREE_NUM-1:0]        i_req_valid,
  input  logic [TREE_NUM-1:0]        i_req_pop,
  input  logic [TREE_NUM*DATA_W-1:0] i_req_data,
  output logic [TREE_NUM-1:0]        o_req_ready,
  output logic [ID_W-1:0]            o_tree_id,
  output logic                       o_push,
  output logic [DATA_W-1:0]          o_push_data,
  output logic                       o_pop,
  input  logic                       i_task_fail,
  input  logic [DATA_W-1:0]          i_pop_data,
  output logic                       o_resp_valid,
  output logic [ID_W-1:0]            o_resp_tree_id,
  output logic [DATA_W-1:0]          o_resp_data,
  output logic                       o_resp_empty,
  output logic                       o_drop,
  output logic [ID_W-1:0]            o_drop_tree_id
);

  localparam int unsigned LV_W = (LEVEL > 1) ? $clog2(LEVEL) : 1;
  localparam int unsigned RC_W = $clog2(RETRY_MAX + 1);
  localparam int unsigned MK_W = $clog2(BACKOFF + 1);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] tree_id;
  } track_t;

  logic [ID_W-1:0]     ptr;
  logic [MK_W-1:0]     mask_cnt  [LEVEL];
  logic [RC_W-1:0]     retry_cnt [TREE_NUM];
  track_t              track     [POP_LAT];

  logic [TREE_NUM-1:0] eligible;
  logic [TREE_NUM-1:0] gnt_oh;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic                gnt_pop;
  logic [DATA_W-1:0]   gnt_data;
  logic [LV_W-1:0]     gnt_root;
  logic                accept;
  logic                fail_hit;
  logic                at_max;
  logic [RC_W-1:0]     retry_inc;

  // Eligibility is gated by reset so no port strobe leaks out while held in reset.
  always_comb begin
    eligible = '0;
    for (int unsigned t = 0; t < TREE_NUM; t++) begin
      eligible[t] = i_arst_n && i_req_valid[t] &&
                    (mask_cnt[LV_W'(root_of(t, LEVEL))] == '0);
    end
  end

  rr_arbiter #(
    .N     (TREE_NUM),
    .IDX_W (ID_W)
  ) u_arb (
    .req   (eligible),
    .ptr   (ptr),
    .grant (gnt_oh),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    gnt_data = '0;
    gnt_pop  = 1'b0;
    for (int unsigned t = 0; t < TREE_NUM; t++) begin
      if (gnt_idx == ID_W'(t)) begin
        gnt_data = i_req_data[t*DATA_W +: DATA_W];
        gnt_pop  = i_req_pop[t];
      end
    end
    gnt_root  = LV_W'(root_of(32'(gnt_idx), LEVEL));
    accept    = gnt_any && !i_task_fail;
    fail_hit  = gnt_any && i_task_fail;
    retry_inc = retry_cnt[gnt_idx] + 1'b1;
    at_max    = fail_hit && (retry_inc == RC_W'(RETRY_MAX));
  end

  always_comb begin
    o_req_ready    = (accept || at_max) ? gnt_oh : '0;
    o_tree_id      = gnt_any ? gnt_idx : '0;
    o_push         = gnt_any && !gnt_pop;
    o_pop          = gnt_any && gnt_pop;
    o_push_data    = gnt_any ? gnt_data : '0;
    o_drop         = at_max;
    o_drop_tree_id = at_max ? gnt_idx : '0;
    o_resp_valid   = track[POP_LAT-1].valid;
    o_resp_tree_id = track[POP_LAT-1].valid ? track[POP_LAT-1].tree_id : '0;
    o_resp_data    = track[POP_LAT-1].valid ? i_pop_data : '0;
    o_resp_empty   = track[POP_LAT-1].valid && (&i_pop_data);
  end

  // A fail below the retry limit parks the pointer on the failing tenant so it
  // is first in line once its root unmasks.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ptr <= '0;
      for (int unsigned l = 0; l < LEVEL; l++) mask_cnt[l] <= '0;
      for (int unsigned t = 0; t < TREE_NUM; t++) retry_cnt[t] <= '0;
      for (int unsigned i = 0; i < POP_LAT; i++) track[i] <= '0;
    end else begin
      if (gnt_any) begin
        ptr <= (accept || at_max) ? gnt_idx + 1'b1 : gnt_idx;
      end
      for (int unsigned l = 0; l < LEVEL; l++) begin
        if (fail_hit && (gnt_root == LV_W'(l))) begin
          mask_cnt[l] <= MK_W'(BACKOFF);
        end else if (mask_cnt[l] != '0) begin
          mask_cnt[l] <= mask_cnt[l] - 1'b1;
        end
      end
      if (accept || at_max) begin
        retry_cnt[gnt_idx] <= '0;
      end else if (fail_hit) begin
        retry_cnt[gnt_idx] <= retry_inc;
      end
      track[0].valid   <= accept && gnt_pop;
      track[0].tree_id <= gnt_idx;
      for (int unsigned i = 1; i < POP_LAT; i++) track[i] <= track[i-1];
    end
  end

endmodule
